// File: rtl/adc_st_packetizer.sv
// adc_st_packetizer: frames a 16-bit ADC sample stream into 512-bit Avalon-ST packets
// (header beat, then rec_len samples packed 32 per beat, EOP/empty on the last beat).
// Ports:
//   clk, reset (sync, active-high)
//   trig, rec_len              - record start pulse and length in samples
//   adc_data, adc_valid        - sample input
//   src_data/valid/ready/sop/eop/empty - Avalon-ST source, ready latency 0
//   busy, overflow, drop_count, seq    - record status
module adc_st_packetizer #(
  parameter int LEN_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trig,
  input  logic [LEN_W-1:0] rec_len,
  input  logic [15:0]      adc_data,
  input  logic             adc_valid,
  output logic [511:0]     src_data,
  output logic             src_valid,
  input  logic             src_ready,
  output logic             src_sop,
  output logic             src_eop,
  output logic [5:0]       src_empty,
  output logic             busy,
  output logic             overflow,
  output logic [15:0]      drop_count,
  output logic [31:0]      seq
);
  typedef enum logic {IDLE, DATA} state_t;
  typedef struct packed {
    logic [511:0] data;
    logic         sop;
    logic         eop;
    logic [5:0]   empty;
  } beat_t;
  state_t state, state_n;
  beat_t h, t, in_b;
  logic [1:0] cnt;
  logic [63:0] ts;
  logic [LEN_W-1:0] len_q, total;
  logic [5:0] lanes, lanes_n;
  logic [511:0] acc, acc_n;
  logic [6:0] gap;
  logic pop, free, take, last, full, move, live, accept, drop, push;
  // h is the head of a 2-entry shift FIFO, t the entry behind it
  assign {src_data, src_sop, src_eop, src_empty} = h;
  assign src_valid = cnt != 2'd0;
  assign pop = src_valid && src_ready;
  assign free = cnt != 2'd2 || pop;
  assign take = state == IDLE && trig && free;
  assign last = total == len_q;
  assign full = lanes == 6'd32 || (lanes != 6'd0 && last);
  assign move = state == DATA && full && free;
  // samples past the record end are ignored rather than counted as drops
  assign live = state == DATA && adc_valid && !last;
  assign accept = live && (!full || move);
  assign drop = live && full && !move;
  assign push = take || move;
  assign gap = 7'd64 - {lanes, 1'b0};
  assign in_b = take ? {384'd0, 32'(rec_len), seq + 32'd1, ts, 1'b1, rec_len == '0, 6'd0}
                     : {acc, 1'b0, last, gap[5:0]};
  assign busy = state == DATA;
  always_comb begin
    state_n = take && rec_len != '0 ? DATA : (move && last ? IDLE : state);
    acc_n = move ? '0 : acc;
    lanes_n = move ? 6'd0 : lanes;
    if (accept) begin
      acc_n[{lanes_n[4:0], 4'd0} +: 16] = adc_data;
      lanes_n = lanes_n + 6'd1;
    end
  end
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (reset) begin
      ts <= '0;
      cnt <= '0;
      h <= '0;
      t <= '0;
      seq <= '0;
      overflow <= 1'b0;
      drop_count <= '0;
      len_q <= '0;
      total <= '0;
      lanes <= '0;
      acc <= '0;
    end else begin
      ts <= ts + 64'd1;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
      if (push && (cnt == 2'd0 || (cnt == 2'd1 && pop))) h <= in_b;
      else if (pop && cnt == 2'd2) h <= t;
      if (push && (cnt == 2'd2 || (cnt == 2'd1 && !pop))) t <= in_b;
      if (take) begin
        len_q <= rec_len;
        seq <= seq + 32'd1;
        overflow <= 1'b0;
        drop_count <= '0;
        total <= '0;
        lanes <= '0;
        acc <= '0;
      end else begin
        if (drop) overflow <= 1'b1;
        if (drop && drop_count != 16'hffff) drop_count <= drop_count + 16'd1;
        if (accept) total <= total + 1'b1;
        lanes <= lanes_n;
        acc <= acc_n;
      end
    end
  end
endmodule

// File: tb/tb_adc_st_packetizer.sv
// tb_adc_st_packetizer: directed stimulus with a beat scoreboard checked by a separate monitor
module tb_adc_st_packetizer;
  localparam int LW = 20;
  typedef struct packed {
    logic [511:0] data;
    logic         sop;
    logic         eop;
    logic [5:0]   empty;
  } beat_t;
  logic clk = 0, reset = 1, trig = 0, adc_valid = 0, src_ready = 1;
  logic [LW-1:0] rec_len = '0;
  logic [15:0] adc_data = '0;
  logic [511:0] src_data;
  logic src_valid, src_sop, src_eop, busy, overflow;
  logic [5:0] src_empty;
  logic [15:0] drop_count;
  logic [31:0] seq;
  int checks = 0, failures = 0, exp_seq = 0;
  logic [63:0] tb_ts;
  beat_t q[$];
  beat_t held, exp_b;
  bit hold = 0;
  adc_st_packetizer #(.LEN_W(LW)) dut (
    .clk(clk), .reset(reset), .trig(trig), .rec_len(rec_len),
    .adc_data(adc_data), .adc_valid(adc_valid),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .src_sop(src_sop), .src_eop(src_eop), .src_empty(src_empty),
    .busy(busy), .overflow(overflow), .drop_count(drop_count), .seq(seq)
  );
  always #5 clk = ~clk;
  always @(posedge clk) tb_ts <= reset ? 64'd0 : tb_ts + 64'd1;
  task automatic chk(input string name, input logic [519:0] act, input logic [519:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (reset) hold <= 0;
    else begin
      if (hold) chk("stall_hold", {src_data, src_sop, src_eop, src_empty}, held);
      if (src_valid && src_ready) begin
        if (q.size() == 0) chk("unexpected_beat", src_valid, 1'b0);
        else begin
          exp_b = q.pop_front();
          chk("beat", {src_data, src_sop, src_eop, src_empty}, exp_b);
        end
      end
      hold <= src_valid && !src_ready;
      held <= {src_data, src_sop, src_eop, src_empty};
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [15:0] smp(input int j, input bit stall);
    return 16'(stall && j >= 64 ? j + 36 : j + 1);
  endfunction
  task automatic wait_idle();
    for (int n = 0; n < 500 && (busy || src_valid); n++) step();
    chk("idle", {busy, src_valid}, 2'b00);
  endtask
  task automatic run_record(input int len, input bit stall, input bit retrig);
    beat_t b;
    int r;
    wait_idle();
    trig = 1;
    rec_len = LW'(len);
    adc_valid = 1;
    adc_data = 16'hbeef;
    src_ready = !stall;
    exp_seq++;
    q.push_back({384'd0, 32'(len), 32'(exp_seq), tb_ts, 1'b1, len == 0, 6'd0});
    for (int s = 0; s * 32 < len; s++) begin
      r = len - s * 32 > 32 ? 32 : len - s * 32;
      b = '0;
      for (int k = 0; k < r; k++) b.data[16*k +: 16] = smp(s * 32 + k, stall);
      b.eop = (s + 1) * 32 >= len;
      b.empty = b.eop ? 6'(2 * (32 - r)) : 6'd0;
      q.push_back(b);
    end
    step();
    trig = 0;
    chk("busy_after_trig", busy, len != 0);
    for (int i = 1; i < 400; i++) begin
      adc_data = 16'(i);
      src_ready = !stall || i >= 100;
      trig = retrig && i == 10;
      step();
      if (!busy) break;
    end
    trig = 0;
    adc_valid = 0;
    src_ready = 1;
    chk("busy_end", busy, 1'b0);
    chk("seq", seq, 32'(exp_seq));
    chk("drop_count", drop_count, stall ? 16'd35 : 16'd0);
    chk("overflow", overflow, stall);
    for (int n = 0; n < 10 && q.size() > 0; n++) step();
    chk("drained", q.size(), 0);
  endtask
  initial begin
    step();
    step();
    chk("rst_valid", src_valid, 1'b0);
    chk("rst_out", {src_data, src_sop, src_eop, src_empty}, 520'd0);
    chk("rst_status", {busy, overflow, drop_count, seq}, 50'd0);
    reset = 0;
    run_record(64, 0, 0);
    run_record(40, 0, 1);
    run_record(0, 0, 0);
    run_record(128, 1, 0);
    wait_idle();
    trig = 1;
    rec_len = LW'(64);
    adc_valid = 1;
    src_ready = 0;
    step();
    trig = 0;
    for (int i = 1; i <= 40; i++) begin
      adc_data = 16'(i);
      step();
    end
    chk("pending_before_reset", src_valid, 1'b1);
    reset = 1;
    q.delete();
    step();
    chk("reset_valid", src_valid, 1'b0);
    chk("reset_seq", seq, 32'd0);
    chk("reset_busy", busy, 1'b0);
    reset = 0;
    adc_valid = 0;
    src_ready = 1;
    exp_seq = 0;
    step();
    chk("post_reset_valid", src_valid, 1'b0);
    run_record(64, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
